// File: rtl/fir_pkg.sv
// Shared declarations for the FIR stream sequencer: controller states and tap geometry.
package fir_pkg;
   localparam int NUM_TAPS = 8;
   localparam int TAP_AW   = 3;

   typedef enum logic [1:0] {FILL, RUN, DRAIN, COMMIT} state_t;
endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous result FIFO with a flush-style clear; push and pop in one cycle keep the count.
module fir_out_fifo #(
   parameter int bit_width = 16,
   parameter int OUT_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           push,
   input  logic signed [bit_width-1:0]    push_data,
   input  logic                           pop,
   output logic signed [bit_width-1:0]    pop_data,
   output logic [$clog2(OUT_DEPTH+1)-1:0] count,
   output logic                           empty
);
   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

   logic signed [bit_width-1:0] mem [OUT_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty    = (count == '0);
   assign do_push  = push && !clr;
   assign do_pop   = pop && !empty && !clr;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   // The credit scheme upstream must make a push into a full FIFO impossible.
   assert property (@(posedge clk) disable iff (rst)
      !(do_push && !do_pop && (count == CW'(OUT_DEPTH))));
endmodule

// File: rtl/fir_stream_sequencer.sv
// Stream controller for the 8-tap FIR: delay line, double-buffered coefficients,
// commit FSM, latency tracking and credit-based output FIFO.
module fir_stream_sequencer
   import fir_pkg::*;
#(
   parameter int bit_width = 16,
   parameter int OUT_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [bit_width-1:0] in_data,
   input  logic                        flush,
   input  logic                        coef_wr_en,
   input  logic [TAP_AW-1:0]           coef_wr_addr,
   input  logic signed [bit_width-1:0] coef_wr_data,
   input  logic                        mode_wr,
   input  logic                        coef_commit,
   output logic                        commit_busy,
   output logic signed [bit_width-1:0] fir_x     [0:NUM_TAPS-1],
   output logic signed [bit_width-1:0] fir_coeff [0:NUM_TAPS-1],
   output logic                        fir_mode,
   input  logic signed [bit_width-1:0] fir_y,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [bit_width-1:0] out_data
);
   localparam int CW = $clog2(OUT_DEPTH + 1);

   state_t                      state, state_nxt;
   logic [3:0]                  fill, fill_nxt;
   logic                        vld_p1, vld_p2;
   logic                        accept, launch, fifo_empty;
   logic [CW-1:0]               fifo_count;
   logic [CW:0]                 occ;
   logic signed [bit_width-1:0] shadow [NUM_TAPS];

   function automatic logic [3:0] sat_fill(input logic [3:0] f);
      return (f >= 4'(NUM_TAPS)) ? 4'(NUM_TAPS) : f + 4'd1;
   endfunction

   // Results already queued plus those still inside the filter pipe.
   assign occ = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1} + {{CW{1'b0}}, vld_p2};

   assign in_ready    = !rst && ((state == FILL) || (state == RUN)) && (occ < (CW+1)'(OUT_DEPTH));
   assign accept      = in_valid && in_ready && !flush;
   assign fill_nxt    = flush ? 4'd0 : (accept ? sat_fill(fill) : fill);
   assign launch      = accept && (sat_fill(fill) == 4'(NUM_TAPS));
   assign commit_busy = (state == DRAIN) || (state == COMMIT) ||
                        (((state == FILL) || (state == RUN)) && coef_commit);
   assign out_valid   = !fifo_empty;

   always_comb begin
      state_nxt = state;
      case (state)
         FILL, RUN: begin
            if (coef_commit) state_nxt = DRAIN;
            else             state_nxt = (fill_nxt == 4'(NUM_TAPS)) ? RUN : FILL;
         end
         DRAIN:   if (flush || (!vld_p1 && !vld_p2)) state_nxt = COMMIT;
         COMMIT:  state_nxt = (fill_nxt == 4'(NUM_TAPS)) ? RUN : FILL;
         default: state_nxt = FILL;
      endcase
   end

   // Stage p0 -> p1 -> p2: accept edge, filter register edge, FIFO push edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= FILL;
         fill   <= '0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         state  <= state_nxt;
         fill   <= fill_nxt;
         vld_p1 <= !flush && launch;
         vld_p2 <= !flush && vld_p1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_TAPS; k++) fir_x[k] <= '0;
      end else if (flush) begin
         for (int k = 0; k < NUM_TAPS; k++) fir_x[k] <= '0;
      end else if (accept) begin
         fir_x[0] <= in_data;
         for (int k = 1; k < NUM_TAPS; k++) fir_x[k] <= fir_x[k-1];
      end
   end

   // The COMMIT copy reads the shadow before any write landing in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            shadow[k]    <= '0;
            fir_coeff[k] <= '0;
         end
         fir_mode <= 1'b0;
      end else begin
         if (coef_wr_en) shadow[coef_wr_addr] <= coef_wr_data;
         if (state == COMMIT) begin
            for (int k = 0; k < NUM_TAPS; k++) fir_coeff[k] <= shadow[k];
            fir_mode <= mode_wr;
         end
      end
   end

   fir_out_fifo #(
      .bit_width (bit_width),
      .OUT_DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (vld_p2),
      .push_data (fir_y),
      .pop       (out_ready),
      .pop_data  (out_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );
endmodule
